sprite_blitter: RTL and testbench

//  Draws one rectangular 1-bit bitmap sprite (snake segment, apple, wall tile) into the VGA

---
 rtl/blit_pkg.sv | 18 +
 rtl/raster_counter.sv | 36 +++
 rtl/sprite_blitter.sv | 172 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared definitions for the sprite blitter: draw modes, FSM states and screen defaults.
package blit_pkg;

    localparam logic [1:0] MODE_OPAQUE   = 2'b00;
    localparam logic [1:0] MODE_TRANSP   = 2'b01;
    localparam logic [1:0] MODE_ERASE    = 2'b10;
    localparam logic [1:0] MODE_OPAQ_ALT = 2'b11;

    localparam int unsigned SCREEN_W_DEF = 160;
    localparam int unsigned SCREEN_H_DEF = 120;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DRAW = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/raster_counter.sv
// Row-major 2-D scan counter: col advances every enabled cycle, row advances on col wrap.
module raster_counter #(
    parameter int unsigned COLS = 8,
    parameter int unsigned ROWS = 8,
    localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last_c
);

    logic col_wrap_c;

    assign col_wrap_c = (col == CW'(COLS - 1));
    assign last_c     = col_wrap_c && (row == RW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_wrap_c) begin
                col <= '0;
                row <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Draws a 1-bit sprite into the VGA adapter one pixel per clock, with scaling,
// transparency/erase modes and screen-edge clipping.
module sprite_blitter
    import blit_pkg::*;
#(
    parameter int unsigned SPR_W      = 8,
    parameter int unsigned SPR_H      = 8,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned X_W        = 8,
    parameter int unsigned Y_W        = 7,
    parameter int unsigned COL_W      = 3,
    parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H   = SCREEN_H_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic [X_W-1:0]         base_x,
    input  logic [Y_W-1:0]         base_y,
    input  logic [SPR_W*SPR_H-1:0] bitmap,
    input  logic [COL_W-1:0]       fg_colour,
    input  logic [COL_W-1:0]       bg_colour,
    output logic                   busy,
    output logic                   done,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [COL_W-1:0]       vga_colour,
    output logic                   plot
);

    localparam int unsigned COLS   = SPR_W << SCALE_LOG2;
    localparam int unsigned ROWS   = SPR_H << SCALE_LOG2;
    localparam int unsigned N_BITS = SPR_W * SPR_H;
    localparam int unsigned CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned IDX_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    state_t              state;
    logic [1:0]          mode_q;
    logic [X_W-1:0]      base_x_q;
    logic [Y_W-1:0]      base_y_q;
    logic [N_BITS-1:0]   bitmap_q;
    logic [COL_W-1:0]    fg_q;
    logic [COL_W-1:0]    bg_q;
    logic                scan_end;

    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic                last_c;
    logic                cnt_clear_c;
    logic                cnt_en_c;

    logic [IDX_W-1:0]    bit_idx_c;
    logic                src_bit_c;
    logic [X_W:0]        x_sum_c;
    logic [Y_W:0]        y_sum_c;
    logic                visible_c;
    logic                pix_plot_c;
    logic [COL_W-1:0]    pix_colour_c;

    // Counter is held at the origin while idle so a new draw always starts at pixel 0.
    assign cnt_clear_c = (state == ST_IDLE);
    assign cnt_en_c    = (state == ST_DRAW) && !abort && !scan_end;

    raster_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_raster (
        .clk    (clk),
        .resetn (resetn),
        .clear  (cnt_clear_c),
        .en     (cnt_en_c),
        .col    (col),
        .row    (row),
        .last_c (last_c)
    );

    // Source bit select, screen coordinate, clip and colour for the current scan position.
    always_comb begin
        bit_idx_c    = IDX_W'(N_BITS - 1)
                     - (IDX_W'(row >> SCALE_LOG2) * IDX_W'(SPR_W) + IDX_W'(col >> SCALE_LOG2));
        src_bit_c    = bitmap_q[bit_idx_c];
        x_sum_c      = (X_W + 1)'(base_x_q) + (X_W + 1)'(col);
        y_sum_c      = (Y_W + 1)'(base_y_q) + (Y_W + 1)'(row);
        visible_c    = !x_sum_c[X_W] && (x_sum_c < (X_W + 1)'(SCREEN_W))
                    && !y_sum_c[Y_W] && (y_sum_c < (Y_W + 1)'(SCREEN_H));
        pix_plot_c   = visible_c;
        pix_colour_c = src_bit_c ? fg_q : bg_q;
        unique case (mode_q)
            MODE_TRANSP: begin
                pix_plot_c   = visible_c && src_bit_c;
                pix_colour_c = fg_q;
            end
            MODE_ERASE: begin
                pix_colour_c = bg_q;
            end
            MODE_OPAQUE, MODE_OPAQ_ALT: begin
                pix_colour_c = src_bit_c ? fg_q : bg_q;
            end
        endcase
    end

    // Control FSM with input latches and registered pixel outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            plot       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            mode_q     <= '0;
            base_x_q   <= '0;
            base_y_q   <= '0;
            bitmap_q   <= '0;
            fg_q       <= '0;
            bg_q       <= '0;
            scan_end   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    plot <= 1'b0;
                    if (start) begin
                        state    <= ST_DRAW;
                        busy     <= 1'b1;
                        scan_end <= 1'b0;
                        mode_q   <= mode;
                        base_x_q <= base_x;
                        base_y_q <= base_y;
                        bitmap_q <= bitmap;
                        fg_q     <= fg_colour;
                        bg_q     <= bg_colour;
                    end
                end
                ST_DRAW: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        plot  <= 1'b0;
                    end else if (scan_end) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        plot  <= 1'b0;
                    end else begin
                        vga_x <= x_sum_c[X_W-1:0];
                        vga_y <= y_sum_c[Y_W-1:0];
                        plot  <= pix_plot_c;
                        if (pix_plot_c) begin
                            vga_colour <= pix_colour_c;
                        end
                        if (last_c) begin
                            scan_end <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: an unscaled and a 2x-scaled instance share stimulus.
module tb_sprite_blitter;

    typedef struct {
        int t;
        int x;
        int y;
        int c;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [7:0]  base_x;
    logic [6:0]  base_y;
    logic [63:0] bitmap;
    logic [2:0]  fg_colour;
    logic [2:0]  bg_colour;

    logic        bz [2];
    logic        dn [2];
    logic        pl [2];
    logic [7:0]  vx [2];
    logic [6:0]  vy [2];
    logic [2:0]  vc [2];

    exp_t        pq [2][$];
    int          dq [2][$];
    bit          prev_done [2];
    exp_t        mon_e;
    int          mon_d;

    int          ncyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic [1:0]  cur_mode;
    int          cur_bx, cur_by, cur_fg, cur_bg;
    logic [63:0] cur_bm;

    always #5 clk = ~clk;

    sprite_blitter #(.SCALE_LOG2(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort), .mode(mode),
        .base_x(base_x), .base_y(base_y), .bitmap(bitmap),
        .fg_colour(fg_colour), .bg_colour(bg_colour),
        .busy(bz[0]), .done(dn[0]), .vga_x(vx[0]), .vga_y(vy[0]),
        .vga_colour(vc[0]), .plot(pl[0])
    );

    sprite_blitter #(.SCALE_LOG2(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort), .mode(mode),
        .base_x(base_x), .base_y(base_y), .bitmap(bitmap),
        .fg_colour(fg_colour), .bg_colour(bg_colour),
        .busy(bz[1]), .done(dn[1]), .vga_x(vx[1]), .vga_y(vy[1]),
        .vga_colour(vc[1]), .plot(pl[1])
    );

    function automatic void chk(input bit ok, input string name, input string msg);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: %s", name, msg);
        end
    endfunction

    // Monitor: every negedge, match DUT plots and done pulses against the expected queues.
    always @(negedge clk) begin
        ncyc++;
        for (int i = 0; i < 2; i++) begin
            if (pl[i]) begin
                if (pq[i].size() == 0) begin
                    chk(1'b0, "plot_unexpected", $sformatf("dut%0d t=%0d got (%0d,%0d) c=%0d, want no plot",
                        i, ncyc, vx[i], vy[i], vc[i]));
                end else begin
                    mon_e = pq[i].pop_front();
                    chk(mon_e.t == ncyc && mon_e.x == int'(vx[i]) && mon_e.y == int'(vy[i]) && mon_e.c == int'(vc[i]),
                        "pixel", $sformatf("dut%0d got t=%0d (%0d,%0d) c=%0d, want t=%0d (%0d,%0d) c=%0d",
                        i, ncyc, vx[i], vy[i], vc[i], mon_e.t, mon_e.x, mon_e.y, mon_e.c));
                end
            end
            if (pq[i].size() > 0 && pq[i][0].t < ncyc) begin
                mon_e = pq[i].pop_front();
                chk(1'b0, "pixel_missing", $sformatf("dut%0d got no plot by t=%0d, want (%0d,%0d) c=%0d at t=%0d",
                    i, ncyc, mon_e.x, mon_e.y, mon_e.c, mon_e.t));
            end
            if (dn[i]) begin
                if (dq[i].size() == 0) begin
                    chk(1'b0, "done_unexpected", $sformatf("dut%0d got done at t=%0d, want none", i, ncyc));
                end else begin
                    mon_d = dq[i].pop_front();
                    chk(mon_d == ncyc, "done_time", $sformatf("dut%0d got done at t=%0d, want t=%0d", i, ncyc, mon_d));
                end
            end
            if (dq[i].size() > 0 && dq[i][0] < ncyc) begin
                mon_d = dq[i].pop_front();
                chk(1'b0, "done_missing", $sformatf("dut%0d got no done by t=%0d, want t=%0d", i, ncyc, mon_d));
            end
            if (prev_done[i]) begin
                chk(!dn[i] && !bz[i], "done_end", $sformatf("dut%0d got done=%0b busy=%0b after pulse, want 0 0",
                    i, dn[i], bz[i]));
            end
            prev_done[i] = dn[i];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model: enumerate the scaled area row-major and keep only plotted pixels.
    task automatic push_draw(input int i, input int k, input int limit);
        int cols, rows, n_tot, row, col, x, y, c;
        bit b, vis, p;
        cols  = 8 << i;
        rows  = 8 << i;
        n_tot = cols * rows;
        for (int n = 0; n < n_tot && n < limit; n++) begin
            row = n / cols;
            col = n % cols;
            b   = cur_bm[63 - ((row >> i) * 8 + (col >> i))];
            x   = cur_bx + col;
            y   = cur_by + row;
            vis = (x < 160) && (y < 120);
            case (cur_mode)
                2'b01:   begin p = vis && b; c = cur_fg; end
                2'b10:   begin p = vis;      c = cur_bg; end
                default: begin p = vis;      c = b ? cur_fg : cur_bg; end
            endcase
            if (p) pq[i].push_back('{k + 2 + n, x, y, c});
        end
        if (limit >= n_tot) dq[i].push_back(k + n_tot + 2);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bz[0] || bz[1]) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) chk(1'b0, "idle_timeout", $sformatf("busy=%0b%0b after %0d cycles, want 00", bz[1], bz[0], n));
    endtask

    task automatic scramble();
        mode      = 2'($urandom);
        base_x    = 8'($urandom);
        base_y    = 7'($urandom);
        bitmap    = {$urandom, $urandom};
        fg_colour = 3'($urandom);
        bg_colour = 3'($urandom);
    endtask

    task automatic launch(input logic [1:0] m, input int bx, input int by, input logic [63:0] bm,
                          input int fg, input int bg, input int limit, input bit with_abort);
        wait_idle();
        mode      = m;
        base_x    = 8'(bx);
        base_y    = 7'(by);
        bitmap    = bm;
        fg_colour = 3'(fg);
        bg_colour = 3'(bg);
        cur_mode  = m;
        cur_bx    = bx;
        cur_by    = by;
        cur_bm    = bm;
        cur_fg    = fg;
        cur_bg    = bg;
        start     = 1'b1;
        abort     = with_abort;
        push_draw(0, ncyc, limit);
        push_draw(1, ncyc, limit);
        tick();
        start = 1'b0;
        abort = 1'b0;
        scramble();
    endtask

    task automatic check_zero(input string name);
        for (int i = 0; i < 2; i++) begin
            chk({bz[i], dn[i], pl[i], vx[i], vy[i], vc[i]} == '0, name,
                $sformatf("dut%0d got busy=%0b done=%0b plot=%0b x=%0d y=%0d c=%0d, want all 0",
                i, bz[i], dn[i], pl[i], vx[i], vy[i], vc[i]));
        end
    endtask

    localparam int FULL = 1 << 30;

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        mode = '0; base_x = '0; base_y = '0; bitmap = '0; fg_colour = '0; bg_colour = '0;
        repeat (3) tick();
        check_zero("reset_state");
        resetn = 1'b1;
        tick();

        launch(2'b00, 16, 0, '1, 6, 1, FULL, 1'b0);
        launch(2'b01, 60, 50, 64'hAA55_AA55_AA55_AA55, 5, 2, FULL, 1'b0);
        launch(2'b01, 40, 20, 64'h8000_0000_0000_0000, 3, 4, FULL, 1'b0);
        launch(2'b00, 156, 116, {$urandom, $urandom}, 7, 1, FULL, 1'b0);
        launch(2'b11, 250, 0, '1, 2, 5, FULL, 1'b0);

        // Abort before pixel 10, then start together with abort while idle.
        launch(2'b00, 10, 10, {$urandom, $urandom}, 1, 6, 10, 1'b0);
        repeat (10) tick();
        abort = 1'b1;
        tick();
        launch(2'b00, 30, 30, {$urandom, $urandom}, 4, 3, FULL, 1'b1);

        // Start pulsed mid-draw must be ignored.
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;

        // Reset mid-draw, then an erase draw.
        launch(2'b00, 5, 5, '1, 7, 0, FULL, 1'b0);
        repeat (4) tick();
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pq[i].delete();
            dq[i].delete();
        end
        tick();
        check_zero("reset_middraw");
        resetn = 1'b1;
        launch(2'b10, 70, 80, {$urandom, $urandom}, 5, 3, FULL, 1'b0);

        for (int r = 0; r < 12; r++) begin
            launch(2'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                   {$urandom, $urandom}, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), FULL, 1'b0);
            if (r % 3 == 0) begin
                repeat (5) tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end

        wait_idle();
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            chk(pq[i].size() == 0 && dq[i].size() == 0, "queue_drain",
                $sformatf("dut%0d left %0d pixels %0d dones outstanding, want 0 0", i, pq[i].size(), dq[i].size()));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
